// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-outstanding 64-bit data memory with a fixed response
//            latency, alignment/range error checking and response backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) << 3;
  // Counter preload; only used when LATENCY > 1, so the clamp never matters.
  localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [63:0] mem_q [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_write;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_accept     = (state_q == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // With LATENCY=1 the commit happens on the acceptance edge itself, so the
  // live request is used in IDLE and the latched copy everywhere else.
  assign w_write = (state_q == S_IDLE) ? req_write : write_q;
  assign w_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign w_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  // Full 64-bit range compare: high address bits can never alias a word.
  assign w_err = (w_addr[2:0] != 3'b000) || (w_addr >= ADDR_LIMIT);
  assign w_idx = w_addr[AW+2:3];

  // Next-state, counter and handshake outputs; handshakes depend on state only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance; req_* is ignored in every other state.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
    end else if (w_accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response payload, loaded once on entering RESP and held until the next one.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (w_enter_resp) begin
      err_q   <= w_err;
      rdata_q <= (!w_err && !w_write) ? mem_q[w_idx] : 64'd0;
    end
  end

  // Storage is never reset; Reset_L gates the write so a request presented
  // while reset is held cannot commit.
  always_ff @(posedge CLK) begin
    if (w_enter_resp && w_write && !w_err && Reset_L) begin
      mem_q[w_idx] <= w_wdata;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder
//            (DEPTH_WORDS=64, LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        CLK;
  logic        Reset_L;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp;
  int n_bad;

  data_mem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (2)
  ) u_dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  // 10 ns clock; inputs driven and outputs sampled on the falling edge.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One full transaction from the IDLE falling edge; stall = cycles rsp_ready
  // is held low once RESP is reached (0 = accept immediately).
  task automatic txn(input string tag, input logic wr, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic exp_err,
                     input logic [63:0] exp_rdata, input int stall);
    check({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (stall == 0);
    step();                                   // acceptance edge
    req_valid = 1'b0;
    req_addr  = 64'h13;                       // garbage, must be ignored
    check({tag, ".wait_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, ".wait_req_ready"}, 64'(req_ready), 64'd0);
    step();                                   // LATENCY=2 edges after acceptance
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, ".rsp_err"},   64'(rsp_err),   64'(exp_err));
    check({tag, ".rsp_rdata"}, rsp_rdata,      exp_rdata);
    for (int i = 1; i < stall; i++) begin
      step();
      check({tag, ".stall_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, ".stall_rdata"}, rsp_rdata,      exp_rdata);
      check({tag, ".stall_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();                                   // edge with rsp_ready=1 -> IDLE
    check({tag, ".done_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, ".done_ready"}, 64'(req_ready), 64'd1);
  endtask

  logic [63:0] b2b_addr [3];
  logic [63:0] b2b_data [3];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    Reset_L   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    rsp_ready = 1'b1;
    #1 Reset_L = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst.req_ready", 64'(req_ready), 64'd1);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.rsp_rdata", rsp_rdata,      64'd0);
    check("rst.rsp_err",   64'(rsp_err),   64'd0);
    Reset_L = 1'b1;

    // Store then load back, first request immediately after reset release
    txn("st10", 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0, 0);
    txn("ld10", 1'b0, 64'h10, 64'd0, 1'b0, 64'hDEADBEEF_CAFEF00D, 0);

    // Misaligned and out-of-range requests
    txn("st0",   1'b1, 64'h0,   64'h1111_2222_3333_4444, 1'b0, 64'd0, 0);
    txn("ld13",  1'b0, 64'h13,  64'd0, 1'b1, 64'd0, 0);
    txn("st200", 1'b1, 64'h200, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, 64'd0, 0);
    txn("ld0",   1'b0, 64'h0,   64'd0, 1'b0, 64'h1111_2222_3333_4444, 0);
    txn("st1f8", 1'b1, 64'h1F8, 64'h6363_6363_6363_6363, 1'b0, 64'd0, 0);
    txn("ld1f8", 1'b0, 64'h1F8, 64'd0, 1'b0, 64'h6363_6363_6363_6363, 0);

    // Backpressure: rsp_ready low for 5 RESP cycles
    txn("stall", 1'b0, 64'h10, 64'd0, 1'b0, 64'hDEADBEEF_CAFEF00D, 5);

    // Reset during WAIT aborts a pending store
    txn("st8", 1'b1, 64'h8, 64'h5555_AAAA_5555_AAAA, 1'b0, 64'd0, 0);
    txn("ld8pre", 1'b0, 64'h8, 64'd0, 1'b0, 64'h5555_AAAA_5555_AAAA, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h8;
    req_wdata = 64'h1;
    step();
    req_valid = 1'b0;
    check("abort.in_wait", 64'(req_ready), 64'd0);
    Reset_L = 1'b0;
    #1;
    check("abort.req_ready", 64'(req_ready), 64'd1);
    check("abort.rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort.rsp_rdata", rsp_rdata,      64'd0);
    check("abort.rsp_err",   64'(rsp_err),   64'd0);
    step();
    Reset_L = 1'b1;
    txn("ld8post", 1'b0, 64'h8, 64'd0, 1'b0, 64'h5555_AAAA_5555_AAAA, 0);

    // Huge address: error, no alias onto word 63
    txn("ldhi", 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 64'd0, 0);
    txn("sthi", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0ABC, 1'b1, 64'd0, 0);
    txn("ld63", 1'b0, 64'h1F8, 64'd0, 1'b0, 64'h6363_6363_6363_6363, 0);

    // Back-to-back loads with req_valid held high: one acceptance per 3 cycles
    b2b_addr[0] = 64'h10; b2b_data[0] = 64'hDEADBEEF_CAFEF00D;
    b2b_addr[1] = 64'h0;  b2b_data[1] = 64'h1111_2222_3333_4444;
    b2b_addr[2] = 64'h8;  b2b_data[2] = 64'h5555_AAAA_5555_AAAA;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b2b.idle_ready", 64'(req_ready), 64'd1);
      req_addr = b2b_addr[i];
      step();
      req_addr = 64'h13;
      check("b2b.wait_ready", 64'(req_ready), 64'd0);
      check("b2b.wait_valid", 64'(rsp_valid), 64'd0);
      step();
      check("b2b.rsp_valid", 64'(rsp_valid), 64'd1);
      check("b2b.rsp_err",   64'(rsp_err),   64'd0);
      check("b2b.rsp_rdata", rsp_rdata,      b2b_data[i]);
      step();
    end
    req_valid = 1'b0;
    check("b2b.end_ready", 64'(req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 64-bit storage words (power of two, 2..1024).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of CLK cycles from request acceptance to rsp_valid (1..15).
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset_L  input  1  meaning the reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder can accept a request.
REQ-007 SHALL have port req_write  input  1  meaning 1=store, 0=load.
REQ-008 SHALL have port req_addr  input  64  meaning the byte address.
REQ-009 SHALL have port req_wdata  input  64  meaning the store data.
REQ-010 SHALL have port rsp_valid  output  1  meaning a response is presented.
REQ-011 SHALL have port rsp_ready  input  1  meaning the initiator accepts the response.
REQ-012 SHALL have port rsp_rdata  output  64  meaning the load data (0 for stores and errors).
REQ-013 SHALL have port rsp_err  output  1  meaning the request was misaligned or out of range.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE, and rsp_valid=1 only in RESP.
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready, latching req_write, req_addr and req_wdata.
REQ-017 SHALL, on acceptance, go to RESP when LATENCY=1; otherwise go to WAIT and load the down-counter with LATENCY-2.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-019 SHALL assert rsp_valid exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL flag an error when latched addr[2:0] != 0 or when latched addr >= DEPTH_WORDS*8, with the full 64-bit compare and no wrap-around.
REQ-021 SHALL use word index = addr[log2(DEPTH_WORDS)+2:3].
REQ-022 SHALL, for a non-error store, write wdata to the indexed word on the edge entering RESP.
REQ-023 SHALL, for any error, leave storage unmodified.
REQ-024 SHALL, for a non-error load, capture the indexed word into rsp_rdata on the edge entering RESP.
REQ-025 SHALL set rsp_rdata=0 for stores and errors.
REQ-026 SHALL hold rsp_rdata and rsp_err stable while in RESP.
REQ-027 SHALL stay in RESP while rsp_ready=0.
REQ-028 SHALL, on an edge in RESP with rsp_ready=1, go to IDLE; req_ready then rises the following cycle, so there is no same-cycle turnaround.
REQ-029 SHALL ignore req_* inputs outside IDLE.
REQ-030 SHALL NOT combinationally depend req_ready on req_valid.
REQ-031 SHALL give a load after a store to the same word the stored value.

Reset
REQ-032 SHALL, while Reset_L=0, force the state to IDLE, the counter to 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0, regardless of CLK.
REQ-033 SHALL, on reset during WAIT or RESP, abort the transaction; a pending store not yet committed SHALL NOT write.
REQ-034 SHALL leave storage contents unaffected by reset; read-before-write data is undefined.
REQ-035 SHALL accept the first request on the first rising edge after Reset_L deasserts when req_valid=1.

Verification (DEPTH_WORDS=64, LATENCY=2)
REQ-036 SHALL cover: store addr 0x10, data 0xDEADBEEF_CAFEF00D, with rsp_ready=1 -> rsp_valid 2 cycles after acceptance, err=0, rdata=0; a following load from 0x10 -> rdata=0xDEADBEEF_CAFEF00D.
REQ-037 SHALL cover: load addr 0x13 -> rsp_err=1, rdata=0; store addr 0x200 (= 64*8) -> err=1, and a load from 0x0 confirms word 0 is unchanged.
REQ-038 SHALL cover: load with rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable for 5 cycles, req_ready=0; IDLE entered on the edge where rsp_ready=1.
REQ-039 SHALL cover: store to 0x8 of 0x1, then Reset_L pulsed low 1 cycle after acceptance (in WAIT) -> outputs at reset values immediately; a later load of 0x8 returns its prior value, not 0x1.
REQ-040 SHALL cover: address 0xFFFF_FFFF_FFFF_FFF8 -> err=1, with no alias to word 63.
REQ-041 SHALL cover: back-to-back requests with req_valid held 1 -> acceptance every LATENCY+1 = 3 cycles, with responses in order.
